block_average_downscale: RTL and testbench

//  Zoom-out engine; the inverse of the pixel-replication zoom-in block. Reads the
//  160x120 8-bit source frame from a synchronous ROM and writes a reduced frame
//  to the frame-buffer write port by averaging FxF source blocks (F = 1, 2 or 4).

---
 rtl/block_average_downscale.sv | 151 +++++++++++++++
 tb/tb_block_average_downscale.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/block_average_downscale.sv
// block_average_downscale: zoom-out engine. Walks the 160x120 source frame in
// FxF blocks (F = 1, 2, 4), sums each block from a synchronous ROM and writes
// the block average to the frame-buffer write port, one pixel per block.
// Optional build macro BLOCK_AVG_ROUND_EN: round-half-up average instead of
// truncation (F=1 results are identical either way).
module block_average_downscale #(
  parameter int IMG_WIDTH_IN  = 160,
  parameter int IMG_HEIGHT_IN = 120,
  parameter int READ_LATENCY  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [2:0]  zoom_level,
  input  logic [7:0]  pixel_in,
  output logic [14:0] read_addr,
  output logic [7:0]  pixel_out,
  output logic [18:0] write_addr,
  output logic        write_en,
  output logic        done
);

  localparam int STAGES = READ_LATENCY - 1;

  typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

  state_t        state, state_nx;
  logic [1:0]    sh;          // log2 F, latched at frame start
  logic [3:0]    cnt;         // sample index inside block, or drain count
  logic [7:0]    ox, oy;      // output block coordinates
  logic [11:0]   acc;
  logic [STAGES:0] vld_pipe;  // read-issue valid, delayed to match ROM latency

  logic [3:0]    blk_max, dmask, dx, dy;
  logic [7:0]    w_last, h_last;
  logic          read_last, drain_last, frame_last, issue;
  logic [12:0]   sum;
  logic [7:0]    avg;
  logic [14:0]   src_x, src_y;

  // block geometry for the latched zoom factor
  always_comb begin
    blk_max    = 4'((5'd1 << {sh, 1'b0}) - 5'd1);
    dmask      = (4'd1 << sh) - 4'd1;
    dx         = cnt & dmask;
    dy         = cnt >> sh;
    w_last     = 8'((IMG_WIDTH_IN >> sh) - 1);
    h_last     = 8'((IMG_HEIGHT_IN >> sh) - 1);
    read_last  = (cnt == blk_max);
    drain_last = (cnt == 4'(READ_LATENCY - 1));
    frame_last = (ox == w_last) && (oy == h_last);
    issue      = (state == READ);
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state: enable low aborts from anywhere
  always_comb begin
    state_nx = state;
    if (!enable) state_nx = IDLE;
    else begin
      case (state)
        IDLE:    state_nx = (zoom_level <= 3'd2) ? READ : DONE;
        READ:    if (read_last)  state_nx = DRAIN;
        DRAIN:   if (drain_last) state_nx = WRITE;
        WRITE:   state_nx = frame_last ? DONE : READ;
        DONE:    state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // latch zoom factor on frame start; later zoom changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh <= 2'd0;
    else if (state == IDLE && state_nx == READ)
      sh <= (zoom_level == 3'd2) ? 2'd0 : (zoom_level == 3'd1) ? 2'd1 : 2'd2;
  end

  // sample / drain counter and output block position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0; ox <= '0; oy <= '0;
    end else if (!enable) begin
      cnt <= '0; ox <= '0; oy <= '0;
    end else begin
      case (state)
        READ:  cnt <= read_last  ? 4'd0 : cnt + 4'd1;
        DRAIN: cnt <= drain_last ? 4'd0 : cnt + 4'd1;
        WRITE: if (!frame_last) begin
          if (ox == w_last) begin
            ox <= '0;
            oy <= oy + 8'd1;
          end else ox <= ox + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // read-valid shift register; flushed on abort so in-flight data is dropped
  generate
    if (STAGES == 0) begin : g_vld1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       vld_pipe <= '0;
        else if (!enable) vld_pipe <= '0;
        else              vld_pipe <= issue;
      end
    end else begin : g_vldn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       vld_pipe <= '0;
        else if (!enable) vld_pipe <= '0;
        else              vld_pipe <= {vld_pipe[STAGES-1:0], issue};
      end
    end
  endgenerate

  // block accumulator; cleared in IDLE and after each write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else if (!enable || state == IDLE || state == WRITE) acc <= '0;
    else if (vld_pipe[STAGES]) acc <= acc + {4'd0, pixel_in};
  end

  // block average
  always_comb begin
`ifdef BLOCK_AVG_ROUND_EN
    sum = {1'b0, acc} + 13'(5'(5'd1 << {sh, 1'b0}) >> 1);
`else
    sum = {1'b0, acc};
`endif
    avg = 8'(sum >> {sh, 1'b0});
  end

  // ports: addresses and data only present in their own states
  always_comb begin
    src_y      = (15'(oy) << sh) + 15'(dy);
    src_x      = (15'(ox) << sh) + 15'(dx);
    read_addr  = (state == READ) ? src_y * 15'(IMG_WIDTH_IN) + src_x : 15'd0;
    write_en   = (state == WRITE);
    write_addr = (state == WRITE) ?
                 ((19'(oy) * 19'(IMG_WIDTH_IN)) >> sh) + 19'(ox) : 19'd0;
    pixel_out  = (state == WRITE) ? avg : 8'd0;
    done       = (state == DONE);
  end

endmodule

// File: tb/tb_block_average_downscale.sv
// Scoreboard bench for block_average_downscale: the stimulus side fills the
// source ROM, computes the expected frame by direct block averaging and queues
// it; the monitor pops one entry per write strobe.
module tb_block_average_downscale;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [2:0]  zoom_level;
  logic [7:0]  pixel_in;
  logic [14:0] read_addr;
  logic [7:0]  pixel_out;
  logic [18:0] write_addr;
  logic        write_en;
  logic        done;

  block_average_downscale #(.IMG_WIDTH_IN(160), .IMG_HEIGHT_IN(120), .READ_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .zoom_level(zoom_level),
    .pixel_in(pixel_in), .read_addr(read_addr), .pixel_out(pixel_out),
    .write_addr(write_addr), .write_en(write_en), .done(done)
  );

  always #5 clk = ~clk;

  // synchronous ROM, one cycle latency
  logic [7:0] mem [0:19199];
  always @(posedge clk) pixel_in <= mem[read_addr];

  typedef struct { int addr; int pix; } exp_t;
  exp_t q[$];
  exp_t mon_e;

  int tests = 0, fails = 0;
  int n_writes = 0;
  int first_pix = -1;

`ifdef BLOCK_AVG_ROUND_EN
  localparam int EXP_T3 = 2;
`else
  localparam int EXP_T3 = 1;
`endif

  // reference: average every FxF block straight from the source array
  task automatic build_expected(input int zoom);
    int f, wo, ho, s;
    exp_t e;
    f  = (zoom == 2) ? 1 : (zoom == 1) ? 2 : 4;
    wo = 160 / f;
    ho = 120 / f;
    q.delete();
    for (int by = 0; by < ho; by++)
      for (int bx = 0; bx < wo; bx++) begin
        s = 0;
        for (int y = 0; y < f; y++)
          for (int x = 0; x < f; x++)
            s += int'(mem[(by * f + y) * 160 + bx * f + x]);
`ifdef BLOCK_AVG_ROUND_EN
        e.pix = (s + (f * f) / 2) / (f * f);
`else
        e.pix = s / (f * f);
`endif
        e.addr = by * wo + bx;
        q.push_back(e);
      end
  endtask

  // monitor: every write strobe must match the head of the queue
  always @(negedge clk) begin
    if (rst_n === 1'b1 && write_en === 1'b1) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write addr=%0d pix=%0d (no write expected)", write_addr, pixel_out);
      end else begin
        mon_e = q.pop_front();
        if (int'(write_addr) != mon_e.addr || int'(pixel_out) != mon_e.pix) begin
          fails++;
          $display("FAIL write_%0d got addr=%0d pix=%0d want addr=%0d pix=%0d",
                   n_writes, write_addr, pixel_out, mon_e.addr, mon_e.pix);
        end
      end
      if (n_writes == 0) first_pix = int'(pixel_out);
      n_writes++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_read_addr"},  int'(read_addr),  0);
    check({name, "_write_addr"}, int'(write_addr), 0);
    check({name, "_pixel_out"},  int'(pixel_out),  0);
    check({name, "_write_en"},   int'(write_en),   0);
    check({name, "_done"},       int'(done),       0);
  endtask

  task automatic start(input int z);
    @(negedge clk);
    zoom_level = 3'(z);
    n_writes   = 0;
    first_pix  = -1;
    enable     = 1'b1;
  endtask

  task automatic stop();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    q.delete();
  endtask

  task automatic wait_writes(input string name, input int target, input int budget);
    int k = 0;
    while (n_writes < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    tests++;
    if (n_writes < target) begin
      fails++;
      $display("FAIL %s_timeout got=%0d writes want=%0d", name, n_writes, target);
    end
  endtask

  task automatic wait_done(input string name, input int budget, output int cyc);
    cyc = 0;
    while (cyc < budget) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) break;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s_timeout got done=0 want done=1 after %0d cycles", name, cyc);
    end
  endtask

  int cyc;

  initial begin
    rst_n = 1'b0; enable = 1'b0; zoom_level = 3'd1;
    for (int a = 0; a < 19200; a++) mem[a] = 8'd0;
    #1;
    check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: zoom 0.5x, flat frame; exact frame length
    for (int a = 0; a < 19200; a++) mem[a] = 8'd100;
    build_expected(1);
    start(1);
    wait_done("t1", 40000, cyc);
    check("t1_done_cycle", cyc, 28801);
    check("t1_writes", n_writes, 4800);
    check("t1_queue_left", q.size(), 0);
    stop();
    check("t1_done_clear", int'(done), 0);

    // 2: zoom 0.25x, random frame with a saturated corner block; zoom
    //    changed mid-frame must be ignored
    for (int a = 0; a < 19200; a++) mem[a] = 8'($urandom);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) mem[y * 160 + x] = 8'd255;
    mem[3 * 160 + 3] = 8'd0;
    build_expected(0);
    start(0);
    repeat (5) @(negedge clk);
    zoom_level = 3'd2;
    wait_done("t2", 30000, cyc);
    check("t2_first_pix", first_pix, 239);
    check("t2_writes", n_writes, 1200);
    check("t2_queue_left", q.size(), 0);
    stop();

    // 3/6: zoom 0.5x {1,2,2,2} corner; abort after 10 writes, restart, reset
    for (int a = 0; a < 19200; a++) mem[a] = 8'($urandom);
    mem[0] = 8'd1; mem[1] = 8'd2; mem[160] = 8'd2; mem[161] = 8'd2;
    build_expected(1);
    start(1);
    wait_writes("t3a", 10, 200);
    check("t3_first_pix", first_pix, EXP_T3);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("t3_abort_write_en", int'(write_en), 0);
    check("t3_abort_done", int'(done), 0);
    q.delete();
    build_expected(1);
    start(1);
    wait_writes("t3b", 20, 300);
    check("t3_restart_first_pix", first_pix, EXP_T3);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("midframe_rst");
    enable = 1'b0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // 4: zoom 1x ramp, pass-through; first 3000 writes
    for (int a = 0; a < 19200; a++) mem[a] = 8'(a);
    build_expected(2);
    start(2);
    wait_writes("t4", 3000, 12000);
    stop();

    // 5: invalid zoom goes straight to DONE with no writes
    check("t5_pre_done", int'(done), 0);
    start(3);
    @(posedge clk); #1;
    check("t5_done_cycle2", int'(done), 1);
    repeat (20) @(negedge clk);
    check("t5_no_writes", n_writes, 0);
    check("t5_done_held", int'(done), 1);
    enable = 1'b0;
    @(posedge clk); #1;
    check("t5_done_clear", int'(done), 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
